piso_serializer: RTL and testbench

- Parametrised parallel-in, serial-out shift register; the successor to the fixed 4-bit serialiser.
- Captures a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, LSB-first or MSB-first (selectable per word).
- Signals frame completion with a one-cycle done pulse.
- Sits between a parallel data producer and a serial line driver.

---
 rtl/piso_serializer.sv | 147 ++++++++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parameterised parallel-in, serial-out shift register.
// Accepts a WIDTH-bit word via a valid/ready handshake. It then shifts
// the word out on tx, one bit per clock. The bit order is LSB-first or
// MSB-first, chosen per word when the word is accepted. A one-cycle done
// pulse marks the end of each frame.
//
// Optional feature macro: PISO_PARITY_EN
//   When defined, an even-parity bit (XOR of the captured word) follows
//   the last data bit, so a frame carries WIDTH+1 bits.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a word; tx at IDLE_LEVEL, ready to accept
// SHIFT  | frame bits on tx, one per cycle; handshake ignored
// DONE   | one-cycle done pulse; a word accepted here starts the next frame
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         msb_first,
    output logic                         tx,
    output logic                         tx_valid,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+2)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic             msb_q;
    logic             accept;
    logic             last_bit;
    logic             next_bit;
    logic             ready_int;

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] LAST_DATA_IDX = CW'(WIDTH - 1);
    logic parity_q;
`endif

    // Handshake and end-of-frame qualifiers, derived from the registered state.
    always_comb begin
        ready_int = (state != S_SHIFT);
        accept    = load_valid && ready_int;
        last_bit  = (state == S_SHIFT) && (count == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SHIFT;
            S_SHIFT: if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = accept ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the registered state only.
    always_comb begin
        load_ready = ready_int;
        busy       = (state == S_SHIFT);
        tx_valid   = (state == S_SHIFT);
        done       = (state == S_DONE);
    end

    // Next shift-register contents and the bit that goes onto tx next.
    // The register already holds the word advanced by one position, so
    // the outgoing end always holds the next bit to send.
    always_comb begin
        shift_nxt = msb_q ? (shift_reg << 1) : (shift_reg >> 1);
        next_bit  = msb_q ? shift_reg[WIDTH-1] : shift_reg[0];
`ifdef PISO_PARITY_EN
        if (count == LAST_DATA_IDX) begin
            next_bit = parity_q;
        end
`endif
    end

    // Datapath. The word is captured on acceptance and its first bit goes
    // straight onto tx, giving one cycle of latency. tx and count are
    // registered so the line driver sees glitch-free outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            msb_q     <= 1'b0;
            tx        <= IDLE_LEVEL;
            count     <= '0;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (accept) begin
            shift_reg <= msb_first ? (data_in << 1) : (data_in >> 1);
            msb_q     <= msb_first;
            tx        <= msb_first ? data_in[WIDTH-1] : data_in[0];
            count     <= '0;
`ifdef PISO_PARITY_EN
            parity_q  <= ^data_in;
`endif
        end else if (state == S_SHIFT) begin
            if (last_bit) begin
                tx    <= IDLE_LEVEL;
                count <= '0;
            end else begin
                tx        <= next_bit;
                count     <= count + 1'b1;
                shift_reg <= shift_nxt;
            end
        end else begin
            tx    <= IDLE_LEVEL;
            count <= '0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer. A scoreboard queue holds the
// expected tx bits: they are pushed when a word is accepted and popped
// on every cycle of the frame.
module tb_piso_serializer;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             msb_first;
    logic             tx;
    logic             tx_valid;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];

    piso_serializer #(.WIDTH(WIDTH), .IDLE_LEVEL(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .msb_first  (msb_first),
        .tx         (tx),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d, input logic m);
        for (int k = 0; k < WIDTH; k++) begin
            exp_q.push_back(m ? d[WIDTH-1-k] : d[k]);
        end
`ifdef PISO_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Present a word for one edge, where the DUT must be ready. Afterwards,
    // scramble the inputs to show that the captured values govern the frame.
    task automatic accept(input logic [WIDTH-1:0] d, input logic m);
        check("ready_at_accept", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        data_in    = d;
        msb_first  = m;
        push_frame(d, m);
        step();
        load_valid = 1'b0;
        data_in    = WIDTH'($urandom);
        msb_first  = 1'($urandom);
    endtask

    task automatic check_bit(input int k);
        logic e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("tx_bit%0d", k), 32'(tx), 32'(e));
        end
        check($sformatf("count_bit%0d", k), 32'(count), 32'(k));
        check("tx_valid_shift", 32'(tx_valid), 32'd1);
        check("busy_shift", 32'(busy), 32'd1);
        check("ready_shift", 32'(load_ready), 32'd0);
        check("done_shift", 32'(done), 32'd0);
    endtask

    task automatic check_done_cycle();
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("tx_valid_done", 32'(tx_valid), 32'd0);
        check("tx_done", 32'(tx), 32'd0);
        check("count_done", 32'(count), 32'd0);
        check("ready_done", 32'(load_ready), 32'd1);
    endtask

    // Check a whole frame, from the cycle after acceptance through the DONE
    // cycle. The handshake is driven with hold_valid/hold_data meanwhile.
    task automatic run_frame(input logic hold_valid, input logic [WIDTH-1:0] hold_data);
        for (int k = 0; k < NBITS; k++) begin
            check_bit(k);
            load_valid = hold_valid;
            data_in    = hold_data;
            step();
        end
        check_done_cycle();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, "_tx"}, 32'(tx), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ready"}, 32'(load_ready), 32'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic             rm;

        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        msb_first  = 1'b0;
        repeat (2) step();
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("idle");

        // LSB-first frame
        accept(8'h1F, 1'b0);
        run_frame(1'b0, 8'h00);
        step();
        check_idle("after_lsb");

        // MSB-first frame
        accept(8'h1F, 1'b1);
        run_frame(1'b0, 8'h00);
        step();
        check_idle("after_msb");

        // load_valid held during SHIFT is ignored; acceptance in DONE runs
        // back-to-back. The bit order changes between these two frames.
        accept(8'h1F, 1'b0);
        load_valid = 1'b1;
        data_in    = 8'hFF;
        run_frame(1'b1, 8'hFF);
        accept(8'h81, 1'b0);
        run_frame(1'b1, 8'hFF);
        accept(8'hC1, 1'b1);
        run_frame(1'b0, 8'h00);
        step();
        check_idle("after_b2b");

        // Reset while count == 3 aborts the frame
        accept(8'h3C, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check_bit(k);
            if (k < 3) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check_idle("abort");
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_done", 32'(done), 32'd0);
        end
        accept(8'hAA, 1'b0);
        run_frame(1'b0, 8'h00);
        step();

        // A few random frames
        for (int i = 0; i < 4; i++) begin
            rd = WIDTH'($urandom);
            rm = 1'($urandom);
            accept(rd, rm);
            run_frame(1'b0, 8'h00);
            step();
        end
        check_idle("final");
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
